// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: decode, drive an external ALU,
// capture its result and hold it as a response until the consumer takes it.
module alu_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_alu_op,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       dec_illegal;
    logic [3:0] dec_ctrl;
    logic       req_hs;
    logic       resp_hs;

    // Returns {illegal, alu_ctrl}; anything outside the supported set is illegal.
    function automatic logic [4:0] decode(input logic [1:0] op,
                                          input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic [4:0] d;
        d = 5'b1_0000;
        case (op)
            2'b00: d = 5'b0_0010;
            2'b01: d = 5'b0_0110;
            2'b10: begin
                case ({f7, f3})
                    10'b0000000_000: d = 5'b0_0010;
                    10'b0100000_000: d = 5'b0_0110;
                    10'b0000000_111: d = 5'b0_0000;
                    10'b0000000_110: d = 5'b0_0001;
                    default:         d = 5'b1_0000;
                endcase
            end
            default: d = 5'b1_0000;
        endcase
        return d;
    endfunction

    assign req_ready  = (state == IDLE) & rst_n;
    assign resp_valid = (state == RESP);
    assign req_hs     = req_valid & req_ready;
    assign resp_hs    = resp_valid & resp_ready;

    always_comb begin
        {dec_illegal, dec_ctrl} = decode(req_alu_op, req_funct3, req_funct7);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    state_nxt = dec_illegal ? RESP : DRIVE;
                end
            end
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_ctrl    <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            op_count    <= '0;
        end else begin
            state <= state_nxt;
            if (req_hs && !dec_illegal) begin
                alu_A    <= req_a;
                alu_B    <= req_b;
                alu_ctrl <= dec_ctrl;
            end
            // Illegal requests bypass the ALU and leave its inputs untouched.
            if (req_hs && dec_illegal) begin
                resp_result <= '0;
                resp_zero   <= 1'b0;
                resp_err    <= 1'b1;
            end
            if (state == CAPTURE) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_err    <= 1'b0;
            end
            if (resp_hs) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
